// File: rtl/reorder_buffer_pkg.sv
// Shared widths, pointer type and entry layout for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH      = 16;
  localparam int unsigned ROB_ADDR_WIDTH = 4;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned RF_ADDR_W      = 5;
  localparam int unsigned EXC_W          = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = EXC_W'(0);

  // Index plus one wrap bit, so full and empty can be told apart.
  typedef logic [ROB_ADDR_WIDTH:0] rob_ptr_t;

  typedef struct packed {
    logic                 reg_write_add;
    logic                 reg_write_en;
    logic [RF_ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0]    reg_write_data;
    logic                 reg_write_lo_en;
    logic [DATA_W-1:0]    reg_write_lo_data;
    logic [EXC_W-1:0]     exception_type;
    logic                 is_delayslot;
    logic [ADDR_W-1:0]    pc;
    logic                 done;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer.
// Ports:
//   clk, rst (async, active-low)
//   write_*   : allocate one entry at the tail; can_write / write_rob_addr_out report tail state
//   update_*  : result writeback by ROB index, marks the entry done
//   commit_*  : head entry presented combinationally; commit_en retires it when can_commit
//   erase_*   : squash from erase_from_addr to the tail by rolling the tail back
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  output logic                      can_write,
  output logic [ROB_ADDR_WIDTH-1:0] write_rob_addr_out,
  input  logic                      write_reg_write_add_in,
  input  logic                      write_reg_write_en_in,
  input  logic [RF_ADDR_W-1:0]      write_reg_write_addr_in,
  input  logic                      write_reg_write_lo_en_in,
  input  logic [EXC_W-1:0]          write_exception_type_in,
  input  logic                      write_is_delayslot_in,
  input  logic [ADDR_W-1:0]         write_pc_in,
  input  logic                      update_en,
  input  logic [ROB_ADDR_WIDTH-1:0] update_addr,
  input  logic [DATA_W-1:0]         update_reg_write_data_in,
  input  logic [DATA_W-1:0]         update_reg_write_lo_data_in,
  input  logic [EXC_W-1:0]          update_exception_type_in,
  input  logic                      commit_en,
  output logic                      can_commit,
  output logic                      commit_reg_write_add_out,
  output logic                      commit_reg_write_en_out,
  output logic [RF_ADDR_W-1:0]      commit_reg_write_addr_out,
  output logic [DATA_W-1:0]         commit_reg_write_data_out,
  output logic                      commit_reg_write_lo_en_out,
  output logic [DATA_W-1:0]         commit_reg_write_lo_data_out,
  output logic [EXC_W-1:0]          commit_exception_type_out,
  output logic                      commit_is_delayslot_out,
  output logic [ADDR_W-1:0]         commit_pc_out,
  input  logic                      erase_en,
  input  logic [ROB_ADDR_WIDTH-1:0] erase_from_addr
);

  rob_ptr_t   head_q, head_d, tail_q, tail_d;
  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];

  logic [ROB_ADDR_WIDTH-1:0] head_idx, tail_idx, upd_off, ers_off;
  rob_ptr_t                  count;
  logic                      empty, full, upd_valid, ers_head;
  logic                      write_fire, commit_fire;

  assign head_idx = head_q[ROB_ADDR_WIDTH-1:0];
  assign tail_idx = tail_q[ROB_ADDR_WIDTH-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[ROB_ADDR_WIDTH] != tail_q[ROB_ADDR_WIDTH]);

  // Offsets relative to the head decide whether an index is currently allocated.
  assign upd_off   = update_addr - head_idx;
  assign upd_valid = ({1'b0, upd_off} < count);
  assign ers_off   = erase_from_addr - head_idx;
  assign ers_head  = erase_en && (ers_off == ROB_ADDR_WIDTH'(0));

  assign can_write          = !full;
  assign write_rob_addr_out = tail_idx;
  assign can_commit         = !empty && entries_q[head_idx].done;

  assign write_fire  = write_en && !full && !erase_en;
  // A commit is lost only when the erase also discards the head entry.
  assign commit_fire = commit_en && can_commit && !ers_head;

  assign commit_reg_write_add_out     = entries_q[head_idx].reg_write_add;
  assign commit_reg_write_en_out      = entries_q[head_idx].reg_write_en;
  assign commit_reg_write_addr_out    = entries_q[head_idx].reg_write_addr;
  assign commit_reg_write_data_out    = entries_q[head_idx].reg_write_data;
  assign commit_reg_write_lo_en_out   = entries_q[head_idx].reg_write_lo_en;
  assign commit_reg_write_lo_data_out = entries_q[head_idx].reg_write_lo_data;
  assign commit_exception_type_out    = entries_q[head_idx].exception_type;
  assign commit_is_delayslot_out      = entries_q[head_idx].is_delayslot;
  assign commit_pc_out                = entries_q[head_idx].pc;

  // Next-state for entries and pointers.
  always_comb begin : next_state
    logic [ROB_ADDR_WIDTH-1:0] off_i;
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    off_i     = '0;

    if (write_fire) begin
      entries_d[tail_idx]                 = '0;
      entries_d[tail_idx].reg_write_add   = write_reg_write_add_in;
      entries_d[tail_idx].reg_write_en    = write_reg_write_en_in;
      entries_d[tail_idx].reg_write_addr  = write_reg_write_addr_in;
      entries_d[tail_idx].reg_write_lo_en = write_reg_write_lo_en_in;
      entries_d[tail_idx].exception_type  = write_exception_type_in;
      entries_d[tail_idx].is_delayslot    = write_is_delayslot_in;
      entries_d[tail_idx].pc              = write_pc_in;
      tail_d = tail_q + rob_ptr_t'(1);
    end

    if (update_en && upd_valid) begin
      entries_d[update_addr].reg_write_data    = update_reg_write_data_in;
      entries_d[update_addr].reg_write_lo_data = update_reg_write_lo_data_in;
      entries_d[update_addr].done              = 1'b1;
      // The first exception seen by an instruction is the one that sticks.
      if (entries_q[update_addr].exception_type == EXC_NONE) begin
        entries_d[update_addr].exception_type = update_exception_type_in;
      end
    end

    if (commit_fire) begin
      entries_d[head_idx].done = 1'b0;
      head_d = head_q + rob_ptr_t'(1);
    end

    if (erase_en) begin
      // Index below the head means the new tail has lapped into the next wrap.
      tail_d = {(erase_from_addr >= head_idx) ? head_q[ROB_ADDR_WIDTH] : ~head_q[ROB_ADDR_WIDTH],
                erase_from_addr};
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        off_i = ROB_ADDR_WIDTH'(i) - head_idx;
        if ((off_i >= ers_off) && ({1'b0, off_i} < count)) begin
          entries_d[i].done = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table plus commit scoreboard.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en, can_write;
  logic [3:0]  write_rob_addr_out;
  logic        write_reg_write_add_in, write_reg_write_en_in, write_reg_write_lo_en_in;
  logic [4:0]  write_reg_write_addr_in, write_exception_type_in;
  logic        write_is_delayslot_in;
  logic [31:0] write_pc_in;
  logic        update_en;
  logic [3:0]  update_addr;
  logic [31:0] update_reg_write_data_in, update_reg_write_lo_data_in;
  logic [4:0]  update_exception_type_in;
  logic        commit_en, can_commit;
  logic        commit_reg_write_add_out, commit_reg_write_en_out, commit_reg_write_lo_en_out;
  logic [4:0]  commit_reg_write_addr_out, commit_exception_type_out;
  logic [31:0] commit_reg_write_data_out, commit_reg_write_lo_data_out, commit_pc_out;
  logic        commit_is_delayslot_out;
  logic        erase_en;
  logic [3:0]  erase_from_addr;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .can_write(can_write), .write_rob_addr_out(write_rob_addr_out),
    .write_reg_write_add_in(write_reg_write_add_in), .write_reg_write_en_in(write_reg_write_en_in),
    .write_reg_write_addr_in(write_reg_write_addr_in), .write_reg_write_lo_en_in(write_reg_write_lo_en_in),
    .write_exception_type_in(write_exception_type_in), .write_is_delayslot_in(write_is_delayslot_in),
    .write_pc_in(write_pc_in),
    .update_en(update_en), .update_addr(update_addr),
    .update_reg_write_data_in(update_reg_write_data_in),
    .update_reg_write_lo_data_in(update_reg_write_lo_data_in),
    .update_exception_type_in(update_exception_type_in),
    .commit_en(commit_en), .can_commit(can_commit),
    .commit_reg_write_add_out(commit_reg_write_add_out), .commit_reg_write_en_out(commit_reg_write_en_out),
    .commit_reg_write_addr_out(commit_reg_write_addr_out), .commit_reg_write_data_out(commit_reg_write_data_out),
    .commit_reg_write_lo_en_out(commit_reg_write_lo_en_out),
    .commit_reg_write_lo_data_out(commit_reg_write_lo_data_out),
    .commit_exception_type_out(commit_exception_type_out), .commit_is_delayslot_out(commit_is_delayslot_out),
    .commit_pc_out(commit_pc_out),
    .erase_en(erase_en), .erase_from_addr(erase_from_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;  logic [31:0] pc;  logic [4:0] wexc;
    logic        ue;  logic [3:0]  ua;  logic [31:0] ud;  logic [4:0] uexc;
    logic        ce;  logic        ee;  logic [3:0]  ef;
    logic        cw;  logic        cc;  logic [3:0]  tail; logic [31:0] cpc;
  } vec_t;

  typedef struct { int idx; logic [31:0] pc; } sb_t;

  vec_t vecs [14];
  sb_t  sbq [$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: head index, occupancy, per-index results.
  int          mh = 0;
  int          cnt = 0;
  logic [31:0] m_data [16];
  logic [31:0] m_lo   [16];
  logic [4:0]  m_exc  [16];
  logic        m_done [16];

  function automatic vec_t mk(logic we, logic [31:0] pc, logic [4:0] wexc,
                              logic ue, logic [3:0] ua, logic [31:0] ud, logic [4:0] uexc,
                              logic ce, logic ee, logic [3:0] ef,
                              logic cw, logic cc, logic [3:0] tail, logic [31:0] cpc);
    vec_t v;
    v.we = we; v.pc = pc; v.wexc = wexc; v.ue = ue; v.ua = ua; v.ud = ud; v.uexc = uexc;
    v.ce = ce; v.ee = ee; v.ef = ef; v.cw = cw; v.cc = cc; v.tail = tail; v.cpc = cpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, score any commit pre-edge, then advance the model.
  task automatic step(input vec_t v);
    bit  wfire, cfire, ufire;
    int  keep, wt, newcnt;
    sb_t e;
    write_en = v.we; write_pc_in = v.pc; write_exception_type_in = v.wexc;
    write_reg_write_en_in = v.we; write_reg_write_addr_in = v.pc[6:2];
    update_en = v.ue; update_addr = v.ua; update_reg_write_data_in = v.ud;
    update_reg_write_lo_data_in = v.ud ^ 32'hffff_0000; update_exception_type_in = v.uexc;
    commit_en = v.ce; erase_en = v.ee; erase_from_addr = v.ef;
    #1;
    wfire = v.we && (cnt < 16) && !v.ee;
    keep  = v.ee ? ((int'(v.ef) - mh) & 15) : cnt;
    cfire = v.ce && (cnt > 0) && m_done[mh] && !(v.ee && keep == 0);
    ufire = v.ue && (((int'(v.ua) - mh) & 15) < cnt);
    wt    = (mh + cnt) & 15;
    if (cfire) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("commit_pc", commit_pc_out, e.pc);
        check("commit_data", commit_reg_write_data_out, m_data[e.idx]);
        check("commit_lo", commit_reg_write_lo_data_out, m_lo[e.idx]);
        check("commit_exc", 32'(commit_exception_type_out), 32'(m_exc[e.idx]));
      end
    end
    @(posedge clk);
    #1;
    if (ufire) begin
      m_data[v.ua] = v.ud;
      m_lo[v.ua]   = v.ud ^ 32'hffff_0000;
      m_done[v.ua] = 1'b1;
      if (m_exc[v.ua] == 5'd0) m_exc[v.ua] = v.uexc;
    end
    if (cfire) begin
      m_done[mh] = 1'b0;
    end
    if (wfire) begin
      m_data[wt] = '0; m_lo[wt] = '0; m_exc[wt] = v.wexc; m_done[wt] = 1'b0;
      e.idx = wt; e.pc = v.pc;
      sbq.push_back(e);
    end
    if (v.ee) begin
      newcnt = keep - (cfire ? 1 : 0);
      while (sbq.size() > newcnt) void'(sbq.pop_back());
      cnt = newcnt;
    end else begin
      cnt = cnt + (wfire ? 1 : 0) - (cfire ? 1 : 0);
    end
    if (cfire) mh = (mh + 1) & 15;
  endtask

  function automatic vec_t wr(logic [31:0] pc);
    return mk(1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_data[i] = '0; m_lo[i] = '0; m_exc[i] = '0; m_done[i] = 1'b0;
    end
    write_reg_write_add_in = 0; write_reg_write_lo_en_in = 0; write_is_delayslot_in = 0;
    write_en = 0; write_pc_in = 0; write_exception_type_in = 0;
    write_reg_write_en_in = 0; write_reg_write_addr_in = 0;
    update_en = 0; update_addr = 0; update_reg_write_data_in = 0;
    update_reg_write_lo_data_in = 0; update_exception_type_in = 0;
    commit_en = 0; erase_en = 0; erase_from_addr = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_can_write", 32'(can_write), 32'd1);
    check("rst_can_commit", 32'(can_commit), 32'd0);
    check("rst_tail", 32'(write_rob_addr_out), 32'd0);
    check("rst_commit_pc", commit_pc_out, 32'd0);
    check("rst_commit_data", commit_reg_write_data_out, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //            we pc            wx ue ua ud     ux ce ee ef  cw cc tl cpc
    vecs[0]  = mk(1, 32'hbfc00000, 0, 0, 0, 0,     0, 0, 0, 0,  1, 0, 1, 32'hbfc00000);
    vecs[1]  = mk(1, 32'hbfc00004, 0, 0, 0, 0,     0, 0, 0, 0,  1, 0, 2, 32'hbfc00000);
    vecs[2]  = mk(0, 0,            0, 1, 0, 32'h11, 0, 0, 0, 0, 1, 1, 2, 32'hbfc00000);
    vecs[3]  = mk(1, 32'hbfc00008, 0, 1, 1, 32'h22, 0, 1, 0, 0, 1, 1, 3, 32'hbfc00004);
    vecs[4]  = mk(0, 0,            0, 0, 0, 0,     0, 0, 1, 1,  1, 0, 1, 32'hbfc00004);
    vecs[5]  = mk(1, 32'hbfc00010, 0, 0, 0, 0,     0, 0, 0, 0,  1, 0, 2, 32'hbfc00010);
    vecs[6]  = mk(1, 32'hbfc00014, 3, 1, 1, 32'h55, 7, 0, 0, 0, 1, 1, 3, 32'hbfc00010);
    vecs[7]  = mk(0, 0,            0, 1, 2, 32'h66, 9, 1, 0, 0, 1, 1, 3, 32'hbfc00014);
    vecs[8]  = mk(1, 32'hbfc00018, 0, 0, 0, 0,     0, 1, 0, 0,  1, 0, 4, 32'hbfc00018);
    vecs[9]  = mk(0, 0,            0, 0, 0, 0,     0, 1, 0, 0,  1, 0, 4, 32'hbfc00018);
    vecs[10] = mk(1, 32'hbfc0001c, 0, 0, 0, 0,     0, 0, 0, 0,  1, 0, 5, 32'hbfc00018);
    vecs[11] = mk(0, 0,            0, 1, 3, 32'h77, 0, 0, 1, 4, 1, 1, 4, 32'hbfc00018);
    vecs[12] = mk(0, 0,            0, 0, 0, 0,     0, 1, 1, 4,  1, 0, 4, 32'hbfc0001c);
    vecs[13] = mk(1, 32'hbfc00020, 0, 0, 0, 0,     0, 0, 1, 4,  1, 0, 4, 32'hbfc0001c);

    foreach (vecs[i]) begin
      step(vecs[i]);
      check($sformatf("v%0d_can_write", i), 32'(can_write), 32'(vecs[i].cw));
      check($sformatf("v%0d_can_commit", i), 32'(can_commit), 32'(vecs[i].cc));
      check($sformatf("v%0d_tail", i), 32'(write_rob_addr_out), 32'(vecs[i].tail));
      check($sformatf("v%0d_commit_pc", i), commit_pc_out, vecs[i].cpc);
    end

    // Fill to full from head index 4, then exercise the full-buffer corners.
    for (int i = 0; i < 16; i++) step(wr(32'h8000_0000 + 32'(i * 4)));
    check("full_can_write", 32'(can_write), 32'd0);
    check("full_tail", 32'(write_rob_addr_out), 32'd4);
    check("full_can_commit", 32'(can_commit), 32'd0);
    step(wr(32'hdead_beef));
    check("ovf_tail", 32'(write_rob_addr_out), 32'd4);
    check("ovf_can_write", 32'(can_write), 32'd0);
    step(mk(0, 0, 0, 1, 4, 32'haaaa, 2, 0, 0, 0, 0, 0, 0, 0));
    check("full_upd_can_commit", 32'(can_commit), 32'd1);
    step(mk(1, 32'hcafe_f00d, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    check("cmt_wr_can_write", 32'(can_write), 32'd1);
    check("cmt_wr_tail", 32'(write_rob_addr_out), 32'd4);
    step(wr(32'hcafe_0001));
    check("wrap_tail", 32'(write_rob_addr_out), 32'd5);
    check("wrap_full", 32'(can_write), 32'd0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    check("flush_can_write", 32'(can_write), 32'd1);
    check("flush_can_commit", 32'(can_commit), 32'd0);
    check("flush_tail", 32'(write_rob_addr_out), 32'd5);
    check("flush_sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
